// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller:
//     - ALU opcode encodings (ALU control field, OP_W bits wide)
//     - issue FSM state type (IDLE / EXEC / RESP)
//     - op_is_defined(): true for every opcode the ALU implements
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [OP_W-1:0] ALU_MUL   = 5'd2;
    localparam logic [OP_W-1:0] ALU_DIV   = 5'd3;
    localparam logic [OP_W-1:0] ALU_INC   = 5'd4;
    localparam logic [OP_W-1:0] ALU_DEC   = 5'd5;
    localparam logic [OP_W-1:0] ALU_AND   = 5'd6;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd7;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'd8;
    localparam logic [OP_W-1:0] ALU_ENCRY = 5'd9;
    localparam logic [OP_W-1:0] ALU_DECRY = 5'd10;
    localparam logic [OP_W-1:0] ALU_IMMED = 5'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_is_defined(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_INC, ALU_DEC,
            ALU_AND, ALU_OR, ALU_XOR, ALU_ENCRY, ALU_DECRY, ALU_IMMED:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// -----------------------------------------------------------------------------
// alu_rr_arb
//   Two-way request arbiter.
//   Ports:
//     req[1:0]  in  : request vector
//     ptr       in  : index of the requester granted last
//     take      in  : a grant is being consumed this cycle
//     gnt[1:0]  out : one-hot grant (zero when no request)
//     ptr_nxt   out : updated last-grant pointer
//   Macro ALU_ISSUE_RR_EN: defined -> round-robin on ties (the requester not
//   granted last wins, pointer follows every consumed grant); undefined ->
//   fixed priority, requester 0 wins ties and the pointer is passed through.
// -----------------------------------------------------------------------------
module alu_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       take,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

`ifdef ALU_ISSUE_RR_EN
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned; that keeps combinational blocks latch-free.
        gnt     = 2'b00;
        ptr_nxt = ptr;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (take && (gnt != 2'b00)) begin
            ptr_nxt = gnt[1];
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    // Fixed priority keeps no history.
    assign ptr_nxt = ptr;

    logic unused_take;
    assign unused_take = take;
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue controller sharing one combinational ALU between two requesters.
//   A winning request is latched into registered ALU operands (IDLE), the
//   ALU result is captured one cycle later (EXEC), and the tagged result is
//   held on a valid/ready response port until the owner accepts it (RESP).
//
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     req_valid/req_ready[1:0]   : per-requester request handshake
//     req_op0/1, req_a0/1, req_b0/1 : per-requester opcode and operands
//     resp_valid/resp_ready[1:0] : per-requester response handshake
//     resp_data, resp_err        : shared registered result and error flag
//     alu_in1, alu_in2, alu_ctrl : registered ALU inputs
//     alu_out                    : combinational ALU result
//     busy                       : FSM not in IDLE
//     ops_done                   : saturating count of delivered responses
//
//   Parameters: DW (data width), OPW (opcode width, equal to alu_pkg::OP_W),
//   CNTW (ops_done width).
//   Macro ALU_ISSUE_RR_EN: round-robin tie-break with a last-grant pointer;
//   otherwise requester 0 always wins a tie.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [OPW-1:0]  req_op0,
    input  logic [OPW-1:0]  req_op1,
    input  logic [DW-1:0]   req_a0,
    input  logic [DW-1:0]   req_a1,
    input  logic [DW-1:0]   req_b0,
    input  logic [DW-1:0]   req_b1,
    output logic [1:0]      resp_valid,
    input  logic [1:0]      resp_ready,
    output logic [DW-1:0]   resp_data,
    output logic            resp_err,
    output logic [DW-1:0]   alu_in1,
    output logic [DW-1:0]   alu_in2,
    output logic [OPW-1:0]  alu_ctrl,
    input  logic [DW-1:0]   alu_out,
    output logic            busy,
    output logic [CNTW-1:0] ops_done
);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      gnt;
    logic            take;
    logic            owner;
    logic            resp_hs;
    logic            last_ptr;
    logic            arb_ptr_nxt;
    logic            div_by_zero;
    logic            op_ok;
    logic [DW-1:0]   result;
    logic            result_err;

    // A grant is consumed only in IDLE; req_valid bits outside IDLE are ignored.
    assign take    = (state == IDLE) && (req_valid != 2'b00);
    assign resp_hs = (state == RESP) && resp_ready[owner];

    alu_rr_arb u_arb (
        .req     (req_valid),
        .ptr     (last_ptr),
        .take    (take),
        .gnt     (gnt),
        .ptr_nxt (arb_ptr_nxt)
    );

`ifdef ALU_ISSUE_RR_EN
    // Reset value 1 makes requester 0 the first tie winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ptr <= 1'b1;
        end else begin
            last_ptr <= arb_ptr_nxt;
        end
    end
`else
    assign last_ptr = 1'b1;

    logic unused_ptr_nxt;
    assign unused_ptr_nxt = arb_ptr_nxt;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples
        // pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        case (state)
            IDLE: begin
                req_ready = gnt;
                if (take) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = owner ? 2'b10 : 2'b01;
                if (resp_ready[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Datapath: operand latch, result capture, delivered-response counter
    // -------------------------------------------------------------------------
    assign div_by_zero = (alu_ctrl == OPW'(ALU_DIV)) && (alu_in2 == '0);
    assign op_ok       = op_is_defined(OP_W'(alu_ctrl));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_ctrl   <= '0;
            owner      <= 1'b0;
            result     <= '0;
            result_err <= 1'b0;
            ops_done   <= '0;
        end else begin
            // Operands change only on acceptance; they survive the response.
            if (take) begin
                alu_in1  <= gnt[1] ? req_a1  : req_a0;
                alu_in2  <= gnt[1] ? req_b1  : req_b0;
                alu_ctrl <= gnt[1] ? req_op1 : req_op0;
                owner    <= gnt[1];
            end

            // The ALU output is trusted only for defined, non-faulting ops.
            if (state == EXEC) begin
                if (!op_ok || div_by_zero) begin
                    result     <= '0;
                    result_err <= 1'b1;
                end else begin
                    result     <= alu_out;
                    result_err <= 1'b0;
                end
            end

            if (resp_hs && (ops_done != '1)) begin
                ops_done <= ops_done + CNTW'(1);
            end
        end
    end

    assign resp_data = result;
    assign resp_err  = result_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl: a behavioural ALU drives alu_out, directed
//   sequences cover the listed scenarios, then randomized traffic runs with
//   random response back-pressure and occasional request withdrawal.
//   A negedge monitor keeps a transaction-level model (busy/idle, age of the
//   outstanding op, last grant) and a queue of expected responses.
//   ops_done is narrowed so saturation is reached during the random phase.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int TB_DW   = 32;
    localparam int TB_OPW  = 5;
    localparam int TB_CNTW = 4;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [TB_OPW-1:0]   req_op0, req_op1;
    logic [TB_DW-1:0]    req_a0, req_a1, req_b0, req_b1;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [TB_DW-1:0]    resp_data;
    logic                resp_err;
    logic [TB_DW-1:0]    alu_in1, alu_in2;
    logic [TB_OPW-1:0]   alu_ctrl;
    logic [TB_DW-1:0]    alu_out;
    logic                busy;
    logic [TB_CNTW-1:0]  ops_done;

    logic [4:0]  op_r [2];
    logic [31:0] a_r  [2];
    logic [31:0] b_r  [2];
    logic [1:0]  pend;
    logic [1:0]  acc_seen;

    int          checks;
    int          errors;
    logic        mon_en;
    logic        m_busy;
    logic        m_owner;
    logic        m_last;
    int          m_age;
    logic [TB_CNTW-1:0] exp_ops;
    exp_t        sbq [$];

    assign req_op0 = op_r[0];
    assign req_op1 = op_r[1];
    assign req_a0  = a_r[0];
    assign req_a1  = a_r[1];
    assign req_b0  = b_r[0];
    assign req_b1  = b_r[1];

    alu_issue_ctrl #(
        .DW   (TB_DW),
        .OPW  (TB_OPW),
        .CNTW (TB_CNTW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural shared ALU. Faulting cases return junk on purpose.
    always_comb begin
        case (alu_ctrl)
            ALU_ADD:   alu_out = alu_in1 + alu_in2;
            ALU_SUB:   alu_out = alu_in1 - alu_in2;
            ALU_MUL:   alu_out = alu_in1 * alu_in2;
            ALU_DIV:   alu_out = (alu_in2 == 0) ? 32'hFFFF_FFFF : alu_in1 / alu_in2;
            ALU_INC:   alu_out = alu_in1 + 32'd1;
            ALU_DEC:   alu_out = alu_in1 - 32'd1;
            ALU_AND:   alu_out = alu_in1 & alu_in2;
            ALU_OR:    alu_out = alu_in1 | alu_in2;
            ALU_XOR:   alu_out = alu_in1 ^ alu_in2;
            ALU_ENCRY: alu_out = (alu_in1 ^ 32'hA5A5_5A5A) + alu_in2;
            ALU_DECRY: alu_out = (alu_in1 - alu_in2) ^ 32'hA5A5_5A5A;
            ALU_IMMED: alu_out = alu_in2;
            default:   alu_out = 32'hDEAD_BEEF;
        endcase
    end

    // Expected response for a request, straight from the operation rules.
    function automatic exp_t ref_result(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t r;
        r.owner = 1'b0;
        r.err   = 1'b0;
        r.data  = 32'd0;
        case (op)
            ALU_ADD:   r.data = a + b;
            ALU_SUB:   r.data = a - b;
            ALU_MUL:   r.data = a * b;
            ALU_DIV:   if (b == 0) r.err = 1'b1; else r.data = a / b;
            ALU_INC:   r.data = a + 1;
            ALU_DEC:   r.data = a - 1;
            ALU_AND:   r.data = a & b;
            ALU_OR:    r.data = a | b;
            ALU_XOR:   r.data = a ^ b;
            ALU_ENCRY: r.data = (a ^ 32'hA5A5_5A5A) + b;
            ALU_DECRY: r.data = (a - b) ^ 32'hA5A5_5A5A;
            ALU_IMMED: r.data = b;
            default:   r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Winner among the valid requesters seen in an idle cycle.
    function automatic logic [1:0] model_pick(input logic [1:0] v, input logic last);
        if (v == 2'b11) begin
`ifdef ALU_ISSUE_RR_EN
            return last ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] g;
            logic [1:0] ev;
            exp_t       e;
            check("busy", 64'(busy), 64'(m_busy));
            check("ops_done", 64'(ops_done), 64'(exp_ops));
            if (!m_busy) begin
                g = model_pick(req_valid, m_last);
                check("req_ready_idle", 64'(req_ready), 64'(g));
                check("resp_valid_idle", 64'(resp_valid), 64'(0));
                for (int i = 0; i < 2; i++) begin
                    if (req_ready[i]) acc_seen[i] = 1'b1;
                end
                if (g != 2'b00) begin
                    e       = g[1] ? ref_result(req_op1, req_a1, req_b1)
                                   : ref_result(req_op0, req_a0, req_b0);
                    e.owner = g[1];
                    sbq.push_back(e);
                    m_busy  = 1'b1;
                    m_age   = 0;
                    m_owner = g[1];
                    m_last  = g[1];
                end
            end else begin
                check("req_ready_busy", 64'(req_ready), 64'(0));
                m_age++;
                ev = (m_age >= 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
                check("resp_valid", 64'(resp_valid), 64'(ev));
                if (ev != 2'b00) begin
                    check("sb_nonempty", 64'(sbq.size() > 0), 64'(1));
                    if (sbq.size() > 0) begin
                        check("resp_data", 64'(resp_data), 64'(sbq[0].data));
                        check("resp_err", 64'(resp_err), 64'(sbq[0].err));
                        if (resp_ready[m_owner]) begin
                            void'(sbq.pop_front());
                            m_busy = 1'b0;
                            if (exp_ops != '1) exp_ops = exp_ops + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver helpers (all drive changes happen just after a posedge)
    // -------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_seen[i]) begin
                pend[i]     = 1'b0;
                acc_seen[i] = 1'b0;
            end
        end
        req_valid = pend;
    endtask

    task automatic issue(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        op_r[i]   = op;
        a_r[i]    = a;
        b_r[i]    = b;
        pend[i]   = 1'b1;
        req_valid = pend;
    endtask

    task automatic wait_grant(input int i);
        for (int k = 0; k < 40 && pend[i]; k++) begin
            step();
        end
        check("grant_timeout", 64'(pend[i]), 64'(0));
    endtask

    task automatic wait_resp(input int i, input logic [31:0] d, input logic e);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (resp_valid[i]) begin
                seen = 1'b1;
                check("dir_data", 64'(resp_data), 64'(d));
                check("dir_err", 64'(resp_err), 64'(e));
            end
        end
        check("resp_timeout", 64'(seen), 64'(1));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),  64'(0));
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
        check({tag, "_resp_data"},  64'(resp_data),  64'(0));
        check({tag, "_resp_err"},   64'(resp_err),   64'(0));
        check({tag, "_alu_in1"},    64'(alu_in1),    64'(0));
        check({tag, "_alu_in2"},    64'(alu_in2),    64'(0));
        check({tag, "_alu_ctrl"},   64'(alu_ctrl),   64'(0));
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_ops_done"},   64'(ops_done),   64'(0));
    endtask

    task automatic model_reset();
        sbq.delete();
        m_busy    = 1'b0;
        m_owner   = 1'b0;
        m_last    = 1'b1;
        m_age     = 0;
        exp_ops   = '0;
        pend      = 2'b00;
        acc_seen  = 2'b00;
        req_valid = 2'b00;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        checks     = 0;
        errors     = 0;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        resp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            op_r[i] = '0;
            a_r[i]  = '0;
            b_r[i]  = '0;
        end
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        #1 mon_en = 1'b1;
        resp_ready = 2'b11;
        step();

        // Single ADD from requester 0.
        issue(0, ALU_ADD, 32'd5, 32'd7);
        wait_grant(0);
        wait_resp(0, 32'd12, 1'b0);
        @(negedge clk);
        check("ops_after_first", 64'(ops_done), 64'(1));
        step();

        // Simultaneous requests; requester 0 re-requests right after winning.
        issue(0, ALU_SUB, 32'd10, 32'd3);
        issue(1, ALU_XOR, 32'hF0, 32'hFF);
        wait_grant(0);
        check("tie_r1_waiting", 64'(pend[1]), 64'(1));
        issue(0, ALU_ADD, 32'd1, 32'd1);
        wait_resp(0, 32'd7, 1'b0);
`ifdef ALU_ISSUE_RR_EN
        wait_grant(1);
        check("rr_r0_waiting", 64'(pend[0]), 64'(1));
        wait_resp(1, 32'h0F, 1'b0);
        wait_grant(0);
        wait_resp(0, 32'd2, 1'b0);
`else
        wait_grant(0);
        check("fixed_r1_waiting", 64'(pend[1]), 64'(1));
        wait_resp(0, 32'd2, 1'b0);
        wait_grant(1);
        wait_resp(1, 32'h0F, 1'b0);
`endif

        // Error cases and a normal divide.
        issue(0, ALU_DIV, 32'd100, 32'd0);
        wait_grant(0);
        wait_resp(0, 32'd0, 1'b1);
        issue(0, ALU_DIV, 32'd100, 32'd7);
        wait_grant(0);
        wait_resp(0, 32'd14, 1'b0);
        issue(1, 5'h1F, 32'd9, 32'd9);
        wait_grant(1);
        wait_resp(1, 32'd0, 1'b1);

        // Response back-pressure on requester 0 while requester 1 waits.
        resp_ready = 2'b10;
        issue(0, ALU_MUL, 32'd6, 32'd7);
        wait_grant(0);
        issue(1, ALU_ADD, 32'd3, 32'd4);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(resp_valid), 64'(2'b01));
            check("stall_data", 64'(resp_data), 64'(42));
            check("stall_ready", 64'(req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
        end
        step();
        resp_ready = 2'b11;
        wait_grant(1);
        wait_resp(1, 32'd7, 1'b0);

        // Reset while an ENCRY is executing.
        issue(0, ALU_ENCRY, 32'h1234_5678, 32'h0F0F_0F0F);
        wait_grant(0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        check("rst_no_resp", 64'(resp_valid), 64'(0));
        model_reset();
        rst_n = 1'b1;
        #1 mon_en = 1'b1;
        step();

        // First post-reset tie goes to requester 0.
        issue(0, ALU_ADD, 32'd5, 32'd7);
        issue(1, ALU_SUB, 32'd9, 32'd4);
        wait_grant(0);
        check("post_rst_r1_waiting", 64'(pend[1]), 64'(1));
        wait_resp(0, 32'd12, 1'b0);
        wait_grant(1);
        wait_resp(1, 32'd5, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 900; n++) begin
            resp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
                    logic [4:0]  op;
                    logic [31:0] b;
                    op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(12, 31))
                                                     : 5'($urandom_range(0, 11));
                    b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
                    issue(i, op, $urandom(), b);
                end else if (pend[i] && ($urandom_range(0, 99) < 3)) begin
                    pend[i]   = 1'b0;
                    req_valid = pend;
                end
            end
            step();
        end

        // Drain.
        resp_ready = 2'b11;
        for (int k = 0; k < 60 && ((pend != 2'b00) || m_busy); k++) begin
            step();
        end
        check("drain_idle", 64'({pend, m_busy}), 64'(0));
        check("sb_empty", 64'(sbq.size()), 64'(0));
        check("ops_saturated", 64'(ops_done), 64'({TB_CNTW{1'b1}}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
